radar_period_stats: RTL
=======================

// Module: radar_period_stats
// PURPOSE
//   Parametrised radar timing monitor. Measures ARP period (us), ACP count per ARP turn and TRIG period (us).
//   Averages each over a configurable power-of-two window and flags per-channel stability.
//   Sits between the radar edge detectors and the AXI register bank, and feeds CALIBRATED to the simulator core.
//   Adds over the previous generation: windowed running sums, discard of the first partial period, |diff| tolerance
//   without underflow, counter saturation, and optional loss-of-signal detection.
// PARAMETERS
//   DATA_WIDTH   32          width of period/count registers and outputs
//   AVG_LOG2     2           log2 of averaging window depth (DEPTH = 2**AVG_LOG2, 1..6)
//   ARP_TOL      2           max |sample-avg| for ARP channel stability (us)
//   ACP_TOL      2           max |sample-avg| for ACP channel stability (counts)
//   TRIG_TOL     5           max |sample-avg| for TRIG channel stability (us)
//   ARP_LOS_US   10000000    us without ARP before ARP/ACP loss-of-signal (macro only)
//   TRIG_LOS_US  10000       us without TRIG before TRIG loss-of-signal (macro only)
// PORTS
//   S_AXIS_ACLK     in   1           PL system clock; all logic on posedge
//   S_AXIS_ARESETN  in   1           synchronous active-low reset
//   USEC_PE         in   1           1-cycle pulse per microsecond
//   RADAR_ARP_PE    in   1           1-cycle ARP posedge pulse (north)
//   RADAR_ACP_PE    in   1           1-cycle ACP posedge pulse
//   RADAR_TRIG_PE   in   1           1-cycle TRIG posedge pulse
//   CALIBRATED      out  1           AND of RADAR_CAL[2:0]
//   RADAR_CAL       out  3           per-channel stable flags {TRIG,ACP,ARP}
//   RADAR_LOS       out  3           per-channel loss-of-signal {TRIG,ACP,ARP}; constant 0 without macro
//   RADAR_ARP_US    out  DATA_WIDTH  averaged ARP period, us
//   RADAR_ACP_CNT   out  DATA_WIDTH  averaged ACPs per ARP
//   RADAR_TRIG_US   out  DATA_WIDTH  averaged TRIG period, us
// BEHAVIOUR
//   - Reset (ARESETN=0 at clock edge): all outputs, counters, windows, sums, fill counts and armed flags go to 0.
//     Reset mid-operation discards all history; the channel re-arms from scratch.
//   - Channel event / increment source: ARP: ARP_PE / USEC_PE. ACP: ARP_PE / ACP_PE. TRIG: TRIG_PE / USEC_PE.
//   - Accumulator cnt on event: cnt <= inc ? 1 : 0 (an increment coinciding with the event counts into the next period).
//     Otherwise, on increment: cnt <= cnt+1, saturating at all-ones (no wrap).
//   - Armed flag: the first event after reset or LOS only sets armed; the partial period is discarded, not pushed.
//   - Push (event && armed):
//       sample = cnt; circular buffer[wp] <= sample; wp <= wp+1 (mod DEPTH).
//       sum <= sum + sample - buffer[wp] if fill==DEPTH, else sum + sample; fill saturates at DEPTH.
//       sum is DATA_WIDTH+AVG_LOG2 bits; avg = sum >> AVG_LOG2.
//   - Stability is evaluated at push against the pre-push avg, using a DATA_WIDTH+1-bit absolute difference:
//     cal <= (fill==DEPTH) && |sample-avg| <= TOL. cal is registered, so it is valid the cycle after the event.
//   - cal therefore first rises on the (DEPTH+2)th event after reset (1 arms, DEPTH fill, 1 checks).
//   - An out-of-tolerance sample clears cal but is still pushed (window tracks a new rate); cal returns on the next
//     in-tolerance push.
//   - Outputs: while CALIBRATED=1 every cycle RADAR_*_US/CNT <= avg (1-cycle latency). While 0, outputs hold last value.
//   - Simultaneous ARP_PE and ACP_PE: push of ACP count excludes this ACP; the new count starts at 1.
// CONFIGURATION
//   RADAR_STATS_LOS_EN defined:
//     - per-channel idle counter in us (reset on that channel's event, saturating).
//     - ARP idle >= ARP_LOS_US sets LOS[0] and LOS[1]; TRIG idle >= TRIG_LOS_US sets LOS[2].
//     - On LOS set, the channel(s) clear cal, fill, sum and armed; LOS clears on the next channel event,
//       which re-arms only (no push).
//   RADAR_STATS_LOS_EN undefined: no idle counters; RADAR_LOS tied 3'b000; a dead input just holds cal/outputs.
// TESTING
//   1. AVG_LOG2=2; TRIG every 250 us -> RADAR_CAL[2] rises 1 cycle after the 6th TRIG_PE; RADAR_TRIG_US=250 next cycle.
//   2. TRIG_PE coincident with USEC_PE each period (250 us) -> every sample exactly 250; no off-by-one.
//   3. Calibrated at 250, inject one 256 us period -> CAL[2]=0 and CALIBRATED=0, output holds 250;
//      next 250 us period -> CAL[2]=1 again.
//   4. ARP every 10000 us with 1024 ACP each -> CALIBRATED after 6th ARP; ARP_US=10000, ACP_CNT=1024;
//      an ACP coincident with ARP still gives 1024.
//   5. DATA_WIDTH=8, no TRIG for 300 us -> accumulator saturates at 255; ARESETN low 1 cycle mid-run ->
//      all outputs 0, re-cal needs 6 more events.
//   6. RADAR_STATS_LOS_EN, TRIG_LOS_US=1000, TRIG stops -> LOS[2]=1 and CALIBRATED=0 at 1000 us idle;
//      TRIG resumes -> LOS[2]=0, CAL[2] after 6 events. Without macro: LOS stays 0.

Source files
------------

// File: rtl/radar_period_stats.sv
// radar_period_stats: windowed ARP period, ACP-per-turn and TRIG period averaging with per-channel
// stability flags. Define RADAR_STATS_LOS_EN to add loss-of-signal detection (RADAR_LOS).

module radar_period_chan #(
    parameter int DATA_WIDTH = 32,
    parameter int AVG_LOG2   = 2,
    parameter int TOL        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ev,
    input  logic                  inc,
    input  logic                  los_hit,
    output logic                  cal,
    output logic [DATA_WIDTH-1:0] avg
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = DATA_WIDTH + AVG_LOG2;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [AVG_LOG2:0]     FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [DATA_WIDTH:0]   TOL_W     = (DATA_WIDTH + 1)'(TOL);

    logic [DATA_WIDTH-1:0]            cnt_q, cnt_d;
    logic                             armed_q, armed_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [AVG_LOG2-1:0]              wp_q, wp_d;
    logic [AVG_LOG2:0]                fill_q, fill_d;
    logic [SW-1:0]                    sum_q, sum_d;
    logic                             cal_q, cal_d;
    logic                             push;
    logic                             full;
    logic [DATA_WIDTH:0]              diff;

    assign avg = sum_q[SW-1:AVG_LOG2];
    assign cal = cal_q;

    always_comb begin
        push = ev && armed_q;
        full = (fill_q == FILL_FULL);
        // extra bit so the magnitude never underflows at full-scale values
        if (cnt_q >= avg) diff = {1'b0, cnt_q} - {1'b0, avg};
        else              diff = {1'b0, avg} - {1'b0, cnt_q};

        cnt_d   = cnt_q;
        armed_d = armed_q;
        win_d   = win_q;
        wp_d    = wp_q;
        fill_d  = fill_q;
        sum_d   = sum_q;
        cal_d   = cal_q;

        if (ev)                            cnt_d = {{(DATA_WIDTH-1){1'b0}}, inc};
        else if (inc && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;

        if (ev) armed_d = 1'b1;

        if (push) begin
            win_d[wp_q] = cnt_q;
            wp_d        = wp_q + 1'b1;
            if (full) begin
                sum_d = sum_q + SW'(cnt_q) - SW'(win_q[wp_q]);
            end else begin
                sum_d  = sum_q + SW'(cnt_q);
                fill_d = fill_q + 1'b1;
            end
            cal_d = full && (diff <= TOL_W);
        end

        // stale window slots are harmless: fill restarts, so every slot is rewritten before reuse
        if (los_hit) begin
            cal_d   = 1'b0;
            fill_d  = '0;
            sum_d   = '0;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            win_q   <= '0;
            wp_q    <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            cal_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            win_q   <= win_d;
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            sum_q   <= sum_d;
            cal_q   <= cal_d;
        end
    end
endmodule

module radar_period_stats #(
    parameter int DATA_WIDTH  = 32,
    parameter int AVG_LOG2    = 2,
    parameter int ARP_TOL     = 2,
    parameter int ACP_TOL     = 2,
    parameter int TRIG_TOL    = 5
`ifdef RADAR_STATS_LOS_EN
    ,
    parameter int ARP_LOS_US  = 10000000,
    parameter int TRIG_LOS_US = 10000
`endif
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  USEC_PE,
    input  logic                  RADAR_ARP_PE,
    input  logic                  RADAR_ACP_PE,
    input  logic                  RADAR_TRIG_PE,
    output logic                  CALIBRATED,
    output logic [2:0]            RADAR_CAL,
    output logic [2:0]            RADAR_LOS,
    output logic [DATA_WIDTH-1:0] RADAR_ARP_US,
    output logic [DATA_WIDTH-1:0] RADAR_ACP_CNT,
    output logic [DATA_WIDTH-1:0] RADAR_TRIG_US
);
    // channel order {TRIG, ACP, ARP}; ACP is counted per ARP turn
    logic [2:0]                 ev_w;
    logic [2:0]                 inc_w;
    logic [2:0]                 cal_w;
    logic [2:0]                 los_hit;
    logic [2:0][DATA_WIDTH-1:0] avg_w;
    logic [2:0][DATA_WIDTH-1:0] out_q, out_d;

    assign ev_w  = {RADAR_TRIG_PE, RADAR_ARP_PE, RADAR_ARP_PE};
    assign inc_w = {USEC_PE, RADAR_ACP_PE, USEC_PE};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        localparam int TOL_G = (g == 0) ? ARP_TOL : (g == 1) ? ACP_TOL : TRIG_TOL;
        radar_period_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .AVG_LOG2   (AVG_LOG2),
            .TOL        (TOL_G)
        ) u_chan (
            .clk     (S_AXIS_ACLK),
            .rst_n   (S_AXIS_ARESETN),
            .ev      (ev_w[g]),
            .inc     (inc_w[g]),
            .los_hit (los_hit[g]),
            .cal     (cal_w[g]),
            .avg     (avg_w[g])
        );
    end

`ifdef RADAR_STATS_LOS_EN
    localparam int AIW = $clog2(ARP_LOS_US + 2);
    localparam int TIW = $clog2(TRIG_LOS_US + 2);

    logic [AIW-1:0] arp_idle_q, arp_idle_d;
    logic [TIW-1:0] trig_idle_q, trig_idle_d;
    logic [2:0]     los_q, los_d;
    logic           arp_dead, trig_dead;

    always_comb begin
        arp_dead  = (arp_idle_q == AIW'(ARP_LOS_US));
        trig_dead = (trig_idle_q == TIW'(TRIG_LOS_US));

        arp_idle_d = arp_idle_q;
        if (RADAR_ARP_PE)              arp_idle_d = '0;
        else if (USEC_PE && !arp_dead) arp_idle_d = arp_idle_q + 1'b1;

        trig_idle_d = trig_idle_q;
        if (RADAR_TRIG_PE)              trig_idle_d = '0;
        else if (USEC_PE && !trig_dead) trig_idle_d = trig_idle_q + 1'b1;

        // a channel event always wins over a coincident timeout
        los_d = los_q;
        if (RADAR_ARP_PE)  los_d[1:0] = 2'b00;
        else if (arp_dead) los_d[1:0] = 2'b11;
        if (RADAR_TRIG_PE)  los_d[2] = 1'b0;
        else if (trig_dead) los_d[2] = 1'b1;

        los_hit = {trig_dead && !RADAR_TRIG_PE,
                   arp_dead && !RADAR_ARP_PE,
                   arp_dead && !RADAR_ARP_PE};
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            arp_idle_q  <= '0;
            trig_idle_q <= '0;
            los_q       <= '0;
        end else begin
            arp_idle_q  <= arp_idle_d;
            trig_idle_q <= trig_idle_d;
            los_q       <= los_d;
        end
    end

    assign RADAR_LOS = los_q;
`else
    assign los_hit   = 3'b000;
    assign RADAR_LOS = 3'b000;
`endif

    assign RADAR_CAL  = cal_w;
    assign CALIBRATED = &cal_w;

    always_comb begin
        out_d = out_q;
        if (CALIBRATED) out_d = avg_w;
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) out_q <= '0;
        else                 out_q <= out_d;
    end

    assign RADAR_ARP_US  = out_q[0];
    assign RADAR_ACP_CNT = out_q[1];
    assign RADAR_TRIG_US = out_q[2];
endmodule
